// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding memory port and a small
// prefetch FIFO feeding the control unit. Fetch stops at the first HLT word.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 25,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [2:0] OpHlt = 3'b101;
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHalted
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    // Storage needs no reset: an entry is only read once count_q says it was written.
    logic [31:0]       data_q [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];

    logic              push;
    logic              pop;
    logic              head_valid;
    logic [31:0]       head_data;
    logic [ADDR_W-1:0] head_addr;

    // Request depends only on registered state, so it cannot glitch off before the ack.
    assign mem_req    = (state_q == StFetch) && (count_q < CntFull);
    assign mem_addr   = fetch_pc_q;
    assign push       = mem_req && mem_ack;

    assign head_valid = (count_q != '0);
    assign head_data  = data_q[rd_ptr_q];
    assign head_addr  = addr_q[rd_ptr_q];

    assign inst_valid = head_valid && (state_q != StHalted);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? head_data : 32'h0;
    assign pc         = inst_valid ? head_addr : '0;

    assign halted      = (state_q == StHalted);
    assign fetch_count = fetch_count_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_count_d = fetch_count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + CntW'(push) - CntW'(pop);

        if (push) begin
            wr_ptr_d      = wr_ptr_q + PtrW'(1);
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (push && (mem_rdata[31:29] == OpHlt)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && (head_data[31:29] == OpHlt)) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            fetch_pc_q    <= ResetPc;
            fetch_count_q <= 32'h0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            data_q[wr_ptr_q] <= mem_rdata;
            addr_q[wr_ptr_q] <= fetch_pc_q;
        end
    end

`ifndef SYNTHESIS
    a_req_held : assert property (@(posedge CLK) disable iff (RST)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr)));

    a_head_held : assert property (@(posedge CLK) disable iff (RST)
        (inst_valid && !inst_ready) |=> (inst_valid && $stable(inst) && $stable(pc)));

    a_count_range : assert property (@(posedge CLK) disable iff (RST)
        count_q <= CntFull);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model, plus a directed
// address-wrap check on a narrow-address instance.
module tb_fetch_unit;

    localparam int Depth = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [24:0] pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic        RST_w = 1'b1;
    logic        start_w = 1'b0;
    logic        mem_req_w;
    logic [3:0]  mem_addr_w;
    logic        mem_ack_w;
    logic [31:0] mem_rdata_w;
    logic [31:0] inst_w;
    logic        inst_valid_w;
    logic        inst_ready_w = 1'b0;
    logic [3:0]  pc_w;
    logic        halted_w;
    logic [31:0] fetch_count_w;

    always #5 CLK = ~CLK;

    fetch_unit #(.ADDR_W(25), .RESET_PC(0), .DEPTH(Depth)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_unit #(.ADDR_W(4), .RESET_PC(14), .DEPTH(2)) dut_w (
        .CLK(CLK), .RST(RST_w), .start(start_w),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w),
        .mem_rdata(mem_rdata_w),
        .inst(inst_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready_w),
        .pc(pc_w), .halted(halted_w), .fetch_count(fetch_count_w)
    );

    // Zero-wait memory for the wrap instance; the word encodes its own address.
    assign mem_ack_w   = mem_req_w;
    assign mem_rdata_w = {3'b001, 25'd0, mem_addr_w};

    typedef struct packed {
        logic [31:0] data;
        logic [24:0] addr;
    } ent_t;

    ent_t        q_m[$];
    bit          started_m;
    bit          hlt_m;
    bit          halted_m;
    logic [24:0] pc_m;
    logic [31:0] cnt_m;
    logic [31:0] mem[64];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_req();
        return started_m && !hlt_m && (q_m.size() < Depth);
    endfunction

    task automatic reset_model();
        q_m.delete();
        started_m = 1'b0;
        hlt_m     = 1'b0;
        halted_m  = 1'b0;
        pc_m      = 25'd0;
        cnt_m     = 32'd0;
    endtask

    task automatic compare_all();
        bit          v;
        logic [31:0] e_inst;
        logic [24:0] e_pc;
        v      = q_m.size() > 0;
        e_inst = v ? q_m[0].data : 32'h0;
        e_pc   = v ? q_m[0].addr : 25'd0;
        check_eq("mem_req", 32'(mem_req), 32'(exp_req()));
        check_eq("mem_addr", 32'(mem_addr), 32'(pc_m));
        check_eq("inst_valid", 32'(inst_valid), 32'(v));
        check_eq("inst", inst, e_inst);
        check_eq("pc", 32'(pc), 32'(e_pc));
        check_eq("halted", 32'(halted), 32'(halted_m));
        check_eq("fetch_count", fetch_count, cnt_m);
    endtask

    // One clock edge of the reference: pop the head if taken, append the acked word.
    task automatic model_step(input bit st, input bit ack, input bit rdy, input logic [31:0] rd);
        bit req;
        bit val;
        req = exp_req();
        val = q_m.size() > 0;
        if (val && rdy) begin
            if (q_m[0].data[31:29] == 3'b101) halted_m = 1'b1;
            void'(q_m.pop_front());
        end
        if (req && ack) begin
            q_m.push_back('{data: rd, addr: pc_m});
            pc_m  = pc_m + 25'd1;
            cnt_m = cnt_m + 32'd1;
            if (rd[31:29] == 3'b101) hlt_m = 1'b1;
        end
        if (st) started_m = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST        = 1'b1;
        start      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        inst_ready = 1'b0;
        reset_model();
        #1;
        compare_all();
    endtask

    task automatic fill_prog(input int hlt_idx);
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[31:29] == 3'b101) w[31:29] = 3'b100;
            mem[i] = w;
        end
        w = $urandom;
        mem[hlt_idx] = {3'b101, w[28:0]};
    endtask

    task automatic run_prog(input int max_lat, input bit fixed_lat, input int pct,
                            input int hold, input int reset_at_in);
        int          lat;
        bit          pend;
        bit          late;
        int          post;
        int          start_at;
        int          reset_at;
        bit          ack;
        bit          rst_now;
        logic [31:0] rd;
        lat      = 0;
        pend     = 1'b0;
        late     = 1'b0;
        post     = 0;
        reset_at = reset_at_in;
        apply_reset();
        start_at = int'($urandom_range(1, 3));
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            RST = 1'b0;
            compare_all();
            if (halted_m) begin
                if (post == 5) break;
                post++;
            end
            start      = (cyc == start_at) || (post == 1) || ($urandom_range(0, 19) == 0);
            inst_ready = (cyc >= hold) && (int'($urandom_range(1, 100)) <= pct);
            ack        = 1'b0;
            rd         = $urandom;
            rst_now    = 1'b0;
            if (late) begin
                // Ack arriving after reset for the request that reset cut off.
                ack   = 1'b1;
                start = 1'b0;
                late  = 1'b0;
            end else if (exp_req()) begin
                if (!pend) begin
                    pend = 1'b1;
                    lat  = fixed_lat ? max_lat : int'($urandom_range(0, max_lat));
                end
                if (lat == 0) begin
                    ack  = 1'b1;
                    pend = 1'b0;
                    rd   = mem[pc_m[5:0]];
                end else begin
                    lat--;
                end
            end else begin
                ack = ($urandom_range(0, 9) == 0);
            end
            if (cyc == reset_at) begin
                if (exp_req()) rst_now = 1'b1;
                else reset_at++;
            end
            if (rst_now) begin
                RST        = 1'b1;
                start      = 1'b0;
                mem_ack    = 1'b0;
                inst_ready = 1'b0;
                reset_model();
                pend       = 1'b0;
                #1;
                compare_all();
                late     = 1'b1;
                start_at = cyc + 3;
                reset_at = -1;
                continue;
            end
            mem_ack   = ack;
            mem_rdata = rd;
            @(posedge CLK);
            model_step(start, ack, inst_ready, rd);
        end
        if (!halted_m) check_eq("halt_timeout", 32'(halted), 32'd1);
        start      = 1'b0;
        mem_ack    = 1'b0;
        inst_ready = 1'b0;
    endtask

    task automatic wrap_test();
        logic [3:0] a;
        logic [3:0] prev;
        @(negedge CLK);
        RST_w = 1'b1;
        #1;
        check_eq("w_rst_addr", 32'(mem_addr_w), 32'd14);
        check_eq("w_rst_req", 32'(mem_req_w), 32'd0);
        @(negedge CLK);
        RST_w        = 1'b0;
        start_w      = 1'b1;
        inst_ready_w = 1'b1;
        @(negedge CLK);
        start_w = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a    = 4'((14 + k) % 16);
            prev = 4'((13 + k) % 16);
            check_eq("w_req", 32'(mem_req_w), 32'd1);
            check_eq("w_addr", 32'(mem_addr_w), 32'(a));
            check_eq("w_count", fetch_count_w, 32'(k));
            check_eq("w_halted", 32'(halted_w), 32'd0);
            check_eq("w_valid", 32'(inst_valid_w), 32'(k > 0));
            if (k > 0) begin
                check_eq("w_pc", 32'(pc_w), 32'(prev));
                check_eq("w_inst", inst_w, {3'b001, 25'd0, prev});
            end
            @(negedge CLK);
        end
        RST_w        = 1'b1;
        inst_ready_w = 1'b0;
    endtask

    initial begin
        reset_model();
        repeat (2) @(posedge CLK);

        // ADD, SUB, MUL, HLT at 0..3.
        fill_prog(3);
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h2000_0000;
        mem[2] = 32'h6000_0000;
        mem[3] = 32'hA000_0000;
        run_prog(0, 1'b1, 100, 0, -1);
        run_prog(0, 1'b1, 100, 10, -1);
        run_prog(3, 1'b1, 100, 0, -1);

        fill_prog(8);
        run_prog(3, 1'b1, 60, 0, 4);

        for (int r = 0; r < 10; r++) begin
            int pct;
            int rs;
            pct = (r % 3 == 0) ? 30 : ((r % 3 == 1) ? 70 : 100);
            rs  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : -1;
            fill_prog(int'($urandom_range(3, 40)));
            run_prog(int'($urandom_range(0, 3)), 1'b0, pct, int'($urandom_range(0, 8)), rs);
        end

        wrap_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the control unit of the accumulator processor. It keeps the program counter and reads 32-bit instruction words from instruction memory through a req/ack port. Fetched words are buffered in a small prefetch FIFO and offered to the control unit over a valid/ready handshake. Fetching stops once an HLT instruction (opcode inst[31:29] = 3'b101) is fetched; the unit reports halted after the control unit consumes that HLT.

Parameters:
ADDR_W, 25, instruction address width (word-addressed; matches the 25-bit immediate field)
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, leaves IDLE and begins fetching
mem_req  out  1  instruction memory read request
mem_addr  out  ADDR_W  word address of the current request
mem_ack  in  1  read complete; mem_rdata is valid in the same cycle
mem_rdata  in  32  instruction word returned by memory
inst  out  32  instruction at FIFO head (0 when empty)
inst_valid  out  1  FIFO non-empty
inst_ready  in  1  control unit accepts inst this cycle
pc  out  ADDR_W  address of the instruction at FIFO head (0 when empty)
halted  out  1  HLT has been consumed; unit is stopped
fetch_count  out  32  number of words accepted from memory since reset

Behaviour:
- Reset (async, RST=1): state=IDLE, fetch_pc=RESET_PC, FIFO empty, mem_req=0, mem_addr=RESET_PC, inst=0, inst_valid=0, pc=0, halted=0, fetch_count=0. mem_req drops in the same cycle RST asserts.
- States: IDLE, FETCH, DRAIN, HALTED.
  - IDLE: mem_req=0. start=1 -> FETCH. mem_ack is ignored.
  - FETCH: mem_req = (count < DEPTH), combinational on registered state and count. mem_addr = fetch_pc, registered.
  - FETCH, on mem_ack with mem_req=1: push {mem_rdata, fetch_pc}; fetch_pc <= fetch_pc+1 mod 2^ADDR_W (wrap to 0); fetch_count+1 (wraps at 2^32).
  - FETCH, if the acked word has opcode 3'b101: -> DRAIN. The HLT word is pushed normally.
  - DRAIN: mem_req=0. On a handshake of an entry whose opcode is 101 -> HALTED.
  - HALTED: mem_req=0, halted=1, inst_valid=0. Holds until RST; start is ignored.
- At most one outstanding request. mem_req may only assert in FETCH with free space, so it cannot be withdrawn before mem_ack. mem_addr is stable while mem_req=1. Memory may ack in the request cycle (zero-wait) or any later cycle.
- Zero-wait memory with inst_ready=1 gives throughput of 1 instruction/cycle. Latency: ack at cycle N -> inst_valid=1 at N+1.
- Handshake: transfer when inst_valid & inst_ready. inst and pc are stable while inst_valid=1 and inst_ready=0.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Full (count==DEPTH): mem_req=0 until a pop. The request reasserts in the cycle after the pop.
- start while in FETCH or DRAIN: no effect.
- Memory never sees a request beyond the HLT address.

Test Plan:
- Reset, start, zero-wait memory holding ADD 0x00000000 @0, SUB 0x20000000 @1, MUL 0x60000000 @2, inst_ready=1 -> mem_addr 0,1,2 on consecutive cycles; inst_valid rises one cycle after the first ack; pc 0,1,2; fetch_count=3.
- inst_ready=0 after start -> exactly 2 acks, then mem_req=0 with mem_addr=2. Raise inst_ready for 1 cycle -> inst @0 consumed; mem_req reasserts next cycle at addr 2.
- HLT word 0xA0000000 at addr 3 -> no request ever issued for addr 4. halted=1 the cycle after the HLT handshake. A start pulse afterwards leaves halted=1 and mem_req=0.
- mem_ack delayed 3 cycles per request -> mem_req and mem_addr held constant for all 4 cycles; one FIFO push per ack.
- Assert RST while mem_req=1 awaiting ack -> mem_req=0 immediately; a late mem_ack in IDLE is ignored (fetch_count=0). After start, fetch resumes at RESET_PC.
- ADDR_W=4, RESET_PC=14 -> request addresses 14, 15, 0, 1; pc outputs match.
